// File: rtl/alarm_ring_ctrl_if.sv
// Signal bundle between the alarm sources (timebase, comparator, buttons) and the ring controller.
interface alarm_ring_ctrl_if;
   logic       tick_1hz;
   logic       alarm_hit;
   logic       alarm_en;
   logic       btn_stop;
   logic       btn_snooze;
   logic       buzzer;
   logic       ringing;
   logic       snoozing;
   logic [3:0] snooze_cnt;

   modport master (
      output tick_1hz, alarm_hit, alarm_en, btn_stop, btn_snooze,
      input  buzzer, ringing, snoozing, snooze_cnt
   );

   modport slave (
      input  tick_1hz, alarm_hit, alarm_en, btn_stop, btn_snooze,
      output buzzer, ringing, snoozing, snooze_cnt
   );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring sequencer (IDLE/RING/SNOOZE) with beep pattern and auto-stop; all outputs registered, 1-cycle latency.
// Optional macro ALARM_SNOOZE_LIMIT_EN caps accepted snoozes per episode at MAX_SNOOZE.
module alarm_ring_ctrl #(
   parameter int unsigned RING_SECS   = 60,
   parameter int unsigned SNOOZE_SECS = 300,
   parameter int unsigned BEEP_HALF   = 50000000,
   parameter int unsigned MAX_SNOOZE  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   alarm_ring_ctrl_if.slave bus
);

   localparam logic [1:0]  S_IDLE      = 2'd0;
   localparam logic [1:0]  S_RING      = 2'd1;
   localparam logic [1:0]  S_SNOOZE    = 2'd2;
   localparam logic [15:0] RING_LAST   = 16'(RING_SECS - 1);
   localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SECS - 1);
   localparam logic [31:0] BEEP_LAST   = 32'(BEEP_HALF - 1);

   if (RING_SECS == 0 || RING_SECS > 65535 || SNOOZE_SECS == 0 || SNOOZE_SECS > 65535 ||
       BEEP_HALF == 0 || MAX_SNOOZE == 0 || MAX_SNOOZE > 15) begin : g_bad_params
      $error("alarm_ring_ctrl: parameter out of range");
   end

   logic [1:0]  state, state_nx;
   logic [15:0] sec_cnt, sec_nx;
   logic [31:0] beep_cnt, beep_nx;
   logic        buzzer_q, buzzer_nx;
   logic        ringing_q, snoozing_q;
   logic [3:0]  scnt_q, scnt_nx;
   logic        quit;
   logic        snooze_ok;

   assign quit = ~bus.alarm_en | bus.btn_stop;

`ifdef ALARM_SNOOZE_LIMIT_EN
   assign snooze_ok = (scnt_q != 4'(MAX_SNOOZE));
`else
   assign snooze_ok = 1'b1;
`endif

   always_comb begin
      state_nx  = state;
      sec_nx    = sec_cnt;
      beep_nx   = beep_cnt;
      buzzer_nx = 1'b0;
      scnt_nx   = scnt_q;
      case (state)
         S_IDLE: begin
            if (bus.alarm_hit && bus.alarm_en) begin
               state_nx  = S_RING;
               sec_nx    = 16'd0;
               beep_nx   = 32'd0;
               buzzer_nx = 1'b1;
               scnt_nx   = 4'd0;
            end
         end
         S_RING: begin
            if (quit) begin
               state_nx = S_IDLE;
               sec_nx   = 16'd0;
            end else if (bus.btn_snooze && snooze_ok) begin
               state_nx = S_SNOOZE;
               sec_nx   = 16'd0;
               scnt_nx  = (scnt_q == 4'hF) ? scnt_q : scnt_q + 4'd1;
            end else if (bus.tick_1hz && sec_cnt == RING_LAST) begin
               state_nx = S_IDLE;
               sec_nx   = 16'd0;
            end else begin
               // A repeated comparator hit restarts the timeout but keeps the beep phase.
               if (bus.alarm_hit)
                  sec_nx = 16'd0;
               else if (bus.tick_1hz)
                  sec_nx = sec_cnt + 16'd1;
               if (beep_cnt == BEEP_LAST) begin
                  beep_nx   = 32'd0;
                  buzzer_nx = ~buzzer_q;
               end else begin
                  beep_nx   = beep_cnt + 32'd1;
                  buzzer_nx = buzzer_q;
               end
            end
         end
         S_SNOOZE: begin
            if (quit) begin
               state_nx = S_IDLE;
               sec_nx   = 16'd0;
            end else if (bus.tick_1hz) begin
               if (sec_cnt == SNOOZE_LAST) begin
                  state_nx  = S_RING;
                  sec_nx    = 16'd0;
                  beep_nx   = 32'd0;
                  buzzer_nx = 1'b1;
               end else begin
                  sec_nx = sec_cnt + 16'd1;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         sec_cnt    <= 16'd0;
         beep_cnt   <= 32'd0;
         buzzer_q   <= 1'b0;
         ringing_q  <= 1'b0;
         snoozing_q <= 1'b0;
         scnt_q     <= 4'd0;
      end else begin
         state      <= state_nx;
         sec_cnt    <= sec_nx;
         beep_cnt   <= beep_nx;
         buzzer_q   <= buzzer_nx;
         ringing_q  <= (state_nx == S_RING);
         snoozing_q <= (state_nx == S_SNOOZE);
         scnt_q     <= scnt_nx;
      end
   end

   assign bus.buzzer     = buzzer_q;
   assign bus.ringing    = ringing_q;
   assign bus.snoozing   = snoozing_q;
   assign bus.snooze_cnt = scnt_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Scoreboard bench for alarm_ring_ctrl: directed episodes plus random button traffic against a timeline model.
module tb_alarm_ring_ctrl;
   localparam int RING_SECS   = 5;
   localparam int SNOOZE_SECS = 3;
   localparam int BEEP_HALF   = 4;
   localparam int MAX_SNOOZE  = 2;
   localparam int TICK_PER    = 20;
   localparam int M_IDLE = 0, M_RING = 1, M_SNOOZE = 2;

   typedef struct packed {
      logic       buz;
      logic       ring;
      logic       snz;
      logic [3:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alarm_ring_ctrl_if bus();

   alarm_ring_ctrl #(
      .RING_SECS  (RING_SECS),
      .SNOOZE_SECS(SNOOZE_SECS),
      .BEEP_HALF  (BEEP_HALF),
      .MAX_SNOOZE (MAX_SNOOZE)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   exp_t exp_q[$];
   exp_t mon_e, mon_got;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc_n = 0;

   // Model: mode, ticks left before the current timer expires, cycles spent ringing since the last ring entry.
   int m_mode, m_rem, m_rcyc, m_scnt;

   function automatic exp_t model_out();
      exp_t e;
      e.buz  = (m_mode == M_RING) && (((m_rcyc / BEEP_HALF) % 2) == 0);
      e.ring = (m_mode == M_RING);
      e.snz  = (m_mode == M_SNOOZE);
      e.cnt  = 4'(m_scnt);
      return e;
   endfunction

   function automatic void model_reset();
      m_mode = M_IDLE;
      m_rem  = 0;
      m_rcyc = 0;
      m_scnt = 0;
   endfunction

   function automatic void start_ring();
      m_mode = M_RING;
      m_rem  = RING_SECS;
      m_rcyc = 0;
   endfunction

   function automatic void model_step(input logic tick, hit, en, stop, snz);
      bit snooze_allowed;
`ifdef ALARM_SNOOZE_LIMIT_EN
      snooze_allowed = (m_scnt != MAX_SNOOZE);
`else
      snooze_allowed = 1'b1;
`endif
      case (m_mode)
         M_IDLE: if (hit && en) begin
            start_ring();
            m_scnt = 0;
         end
         M_RING: begin
            if (!en || stop)
               m_mode = M_IDLE;
            else if (snz && snooze_allowed) begin
               m_mode = M_SNOOZE;
               m_rem  = SNOOZE_SECS;
               m_scnt = (m_scnt < 15) ? m_scnt + 1 : 15;
            end else if (tick && m_rem == 1)
               m_mode = M_IDLE;
            else begin
               if (hit) m_rem = RING_SECS;
               else if (tick) m_rem--;
               m_rcyc++;
            end
         end
         default: begin
            if (!en || stop)
               m_mode = M_IDLE;
            else if (tick) begin
               if (m_rem == 1) start_ring();
               else m_rem--;
            end
         end
      endcase
   endfunction

   task automatic cyc(input logic hit, en, stop, snz);
      logic tick;
      @(negedge clk);
      tick = ((cyc_n % TICK_PER) == TICK_PER - 1);
      cyc_n++;
      bus.tick_1hz   = tick;
      bus.alarm_hit  = hit;
      bus.alarm_en   = en;
      bus.btn_stop   = stop;
      bus.btn_snooze = snz;
      model_step(tick, hit, en, stop, snz);
      exp_q.push_back(model_out());
   endtask

   task automatic run(input int n, input logic en);
      for (int i = 0; i < n; i++) cyc(1'b0, en, 1'b0, 1'b0);
   endtask

   task automatic idle_inputs();
      bus.tick_1hz   = 1'b0;
      bus.alarm_hit  = 1'b0;
      bus.alarm_en   = 1'b0;
      bus.btn_stop   = 1'b0;
      bus.btn_snooze = 1'b0;
   endtask

   // Monitor: each expectation applies to the outputs right after the edge that sampled its inputs.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {bus.buzzer, bus.ringing, bus.snoozing, bus.snooze_cnt};
            n_vec++;
            if (mon_got !== mon_e) begin
               n_bad++;
               $display("FAIL outputs t=%0t got buz=%b ring=%b snz=%b cnt=%0d, expected buz=%b ring=%b snz=%b cnt=%0d",
                        $time, mon_got.buz, mon_got.ring, mon_got.snz, mon_got.cnt,
                        mon_e.buz, mon_e.ring, mon_e.snz, mon_e.cnt);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      repeat (3) @(negedge clk);
      n_vec++;
      if ({bus.buzzer, bus.ringing, bus.snoozing, bus.snooze_cnt} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset got buz=%b ring=%b snz=%b cnt=%0d, expected all 0",
                  bus.buzzer, bus.ringing, bus.snoozing, bus.snooze_cnt);
      end
      rst_n = 1'b1;

      // Plain ring that runs to auto-stop.
      cyc(1, 1, 0, 0);
      run(RING_SECS * TICK_PER + 10, 1);

      // Two snoozes, then stop and snooze together.
      cyc(1, 1, 0, 0);
      run(7, 1);
      cyc(0, 1, 0, 1);
      run(SNOOZE_SECS * TICK_PER + 5, 1);
      cyc(0, 1, 0, 1);
      run(SNOOZE_SECS * TICK_PER + 5, 1);
      cyc(0, 1, 1, 1);
      run(5, 1);

      // Comparator hit while disarmed.
      cyc(1, 0, 0, 0);
      run(10, 1);

      // Disarm during snooze.
      cyc(1, 1, 0, 0);
      run(5, 1);
      cyc(0, 1, 0, 1);
      run(10, 1);
      cyc(0, 0, 0, 0);
      run(SNOOZE_SECS * TICK_PER + 20, 1);

      // Retrigger after three ticks of ringing.
      cyc(1, 1, 0, 0);
      for (int i = 0; i < 200 && m_rem != RING_SECS - 3; i++) cyc(0, 1, 0, 0);
      run(5, 1);
      cyc(1, 1, 0, 0);
      run(RING_SECS * TICK_PER + 20, 1);

      // Three snooze presses in one episode.
      cyc(1, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         run(5, 1);
         cyc(0, 1, 0, 1);
         run(SNOOZE_SECS * TICK_PER + 5, 1);
      end
      cyc(0, 1, 1, 0);
      run(5, 1);

      // Asynchronous reset while the buzzer is on.
      cyc(1, 1, 0, 0);
      cyc(0, 1, 0, 0);
      @(posedge clk);
      #2;
      n_vec++;
      if (bus.buzzer !== 1'b1) begin
         n_bad++;
         $display("FAIL pre_reset_buzzer got %b, expected 1", bus.buzzer);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.buzzer !== 1'b0 || bus.ringing !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset got buz=%b ring=%b, expected 0 0", bus.buzzer, bus.ringing);
      end
      idle_inputs();
      repeat (2) @(negedge clk);
      model_reset();
      rst_n = 1'b1;

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 59) == 0, $urandom_range(0, 299) != 0,
             $urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0);
      end
      run(3, 1);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #3;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
